// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//
// Bit-serial add/subtract sequencer. A single 1-bit adder cell (two half
// adders plus a carry register) is reused across WIDTH cycles. It walks the
// operands LSB-first, one bit per cycle. Subtraction is a + ~b + 1: b is
// inverted at capture and the carry register is seeded with 1.
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      operation request, honoured only while idle
//   sub    in   1      0: a+b, 1: a-b (captured with start)
//   a      in   WIDTH  operand A (captured with start)
//   b      in   WIDTH  operand B (captured with start)
//   busy   out  1      high whenever the sequencer is not idle
//   done   out  1      one-cycle pulse; sum/cout valid from this cycle on
//   sum    out  WIDTH  result, held until the next completed operation
//   cout   out  1      final carry; for sub, 1 means no borrow (a >= b)
//
// Timing: start sampled at edge N gives WIDTH add cycles (N+1..N+WIDTH), then
// one done cycle (N+WIDTH+1), then idle. Peak rate is one op per WIDTH+2.

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit beyond clog2 so WIDTH=1 still gets a 1-bit counter.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  // ---------------------------------------------------------------------------
  // Shared adder cell: two half adders, carry taken from the register
  // ---------------------------------------------------------------------------
  logic ha0_s, ha0_c;
  logic cell_s, cell_c;
  logic last_bit;
  logic [WIDTH-1:0] acc_shift;

  always_comb begin
    ha0_s  = a_sh_q[0] ^ b_sh_q[0];
    ha0_c  = a_sh_q[0] & b_sh_q[0];
    cell_s = ha0_s ^ carry_q;
    cell_c = ha0_c | (carry_q & ha0_s);
  end

  assign last_bit = (cnt_q == CntLast);

  // The new bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    acc_shift            = acc_q >> 1;
    acc_shift[WIDTH-1]   = cell_s;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (last_bit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      StAdd: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = cell_c;
        acc_d   = acc_shift;
        cnt_d   = cnt_q + CntW'(1);
        // Result registers load on the edge that enters StDone, so sum, cout
        // and done all change on the same edge.
        if (last_bit) begin
          sum_d  = acc_shift;
          cout_d = cell_c;
        end
      end
      StDone: begin
        // Nothing to do; result already registered.
      end
      default: begin
        // Unreachable encodings fall back to holding state.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a WIDTH=8 instance and a WIDTH=1
// instance share the clock. Inputs change and outputs are sampled on the
// falling edge.

module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic       rst8, start8, sub8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8;

  // WIDTH=1 instance signals
  logic       rst1, start1, sub1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, cout1;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst8),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst1),
    .start (start1),
    .sub   (sub1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation, observed for 11 cycles after the capture edge.
  // With disturb set, start is pulsed and operands scrambled while busy.
  task automatic run_op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic ts, input logic [7:0] es, input logic ec,
                         input bit disturb);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    @(negedge clk);
    a8     = ta;
    b8     = tb_v;
    sub8   = ts;
    start8 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        done_at = k;
        check({tag, " sum"}, 32'(sum8), 32'(es));
        check({tag, " cout"}, 32'(cout8), 32'(ec));
      end
      if (disturb && k >= 2 && k <= 9) begin
        start8 = 1'b1;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        sub8   = 1'($urandom);
      end else begin
        start8 = 1'b0;
      end
    end
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd9);
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " done latency"}, 32'(done_at), 32'd9);
    check({tag, " sum held"}, 32'(sum8), 32'(es));
  endtask

  // Back-to-back tables (start held high)
  logic [7:0] bb8_a   [3] = '{8'h12, 8'hC8, 8'h64};
  logic [7:0] bb8_b   [3] = '{8'h34, 8'h64, 8'hC8};
  logic       bb8_sub [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] bb8_sum [3] = '{8'h46, 8'h2C, 8'h9C};
  logic       bb8_co  [3] = '{1'b0, 1'b1, 1'b0};

  logic bb1_a   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic bb1_b   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic bb1_sub [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic bb1_sum [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic bb1_co  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int idx;
    int last;
    int done_seen;
    rst8 = 1'b1; start8 = 1'b1; sub8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    rst1 = 1'b1; start1 = 1'b0; sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    // Reset, with start asserted: reset must win.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset sum", 32'(sum8), 32'd0);
    check("reset cout", 32'(cout8), 32'd0);
    check("reset busy w1", 32'(busy1), 32'd0);
    rst8 = 1'b0; start8 = 1'b0;
    rst1 = 1'b0;

    run_op8("add 5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
    run_op8("add ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op8("sub 10-01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
    run_op8("sub 01-02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_op8("disturbed 37+48", 8'h37, 8'h48, 1'b0, 8'h7F, 1'b0, 1'b1);

    // Reset 4 cycles into ADD: abort, outputs cleared, no done afterwards.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort sum", 32'(sum8), 32'd0);
    check("abort cout", 32'(cout8), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) done_seen++;
    end
    check("abort no activity", 32'(done_seen), 32'd0);

    run_op8("sub 37-37", 8'h37, 8'h37, 1'b1, 8'h00, 1'b1, 1'b0);

    // Back-to-back, WIDTH=8: start held high, new operands after each done.
    @(negedge clk);
    a8 = bb8_a[0]; b8 = bb8_b[0]; sub8 = bb8_sub[0]; start8 = 1'b1;
    idx = 0; last = 0;
    for (int cyc = 1; cyc <= 60 && idx < 3; cyc++) begin
      @(negedge clk);
      if (done8) begin
        check($sformatf("b2b8[%0d] sum", idx), 32'(sum8), 32'(bb8_sum[idx]));
        check($sformatf("b2b8[%0d] cout", idx), 32'(cout8), 32'(bb8_co[idx]));
        check($sformatf("b2b8[%0d] spacing", idx), 32'(cyc - last), idx == 0 ? 32'd9 : 32'd10);
        last = cyc;
        idx++;
        if (idx < 3) begin
          a8 = bb8_a[idx]; b8 = bb8_b[idx]; sub8 = bb8_sub[idx];
        end else begin
          start8 = 1'b0;
        end
      end else if (busy8 && idx > 0 && cyc == last + 5) begin
        check($sformatf("b2b8[%0d] sum stable in ADD", idx), 32'(sum8), 32'(bb8_sum[idx-1]));
      end
    end
    start8 = 1'b0;
    check("b2b8 ops completed", 32'(idx), 32'd3);

    // Back-to-back, WIDTH=1: one op every 3 cycles.
    @(negedge clk);
    a1 = bb1_a[0]; b1 = bb1_b[0]; sub1 = bb1_sub[0]; start1 = 1'b1;
    idx = 0; last = 0;
    for (int cyc = 1; cyc <= 40 && idx < 4; cyc++) begin
      @(negedge clk);
      if (done1) begin
        check($sformatf("w1[%0d] sum", idx), 32'(sum1), 32'(bb1_sum[idx]));
        check($sformatf("w1[%0d] cout", idx), 32'(cout1), 32'(bb1_co[idx]));
        check($sformatf("w1[%0d] spacing", idx), 32'(cyc - last), idx == 0 ? 32'd2 : 32'd3);
        last = cyc;
        idx++;
        if (idx < 4) begin
          a1 = bb1_a[idx]; b1 = bb1_b[idx]; sub1 = bb1_sub[idx];
        end else begin
          start1 = 1'b0;
        end
      end
    end
    start1 = 1'b0;
    check("w1 ops completed", 32'(idx), 32'd4);
    repeat (4) @(negedge clk);
    check("w1 idle at end", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
